// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC IR receiver: FSM state codes, pulse-width
// windows in microseconds, the inactivity timeout and the command-to-key map.
package nec_ir_pkg;

    // Duration counter width; the counter saturates at DUR_MAX.
    localparam int DUR_W = 14;
    localparam logic [DUR_W-1:0] DUR_MAX = 14'd16383;

    // Pulse-width windows, inclusive, in microseconds.
    localparam logic [DUR_W-1:0] LEAD_MARK_MIN  = 14'd8000;
    localparam logic [DUR_W-1:0] LEAD_MARK_MAX  = 14'd10000;
    localparam logic [DUR_W-1:0] LEAD_SPACE_MIN = 14'd4000;
    localparam logic [DUR_W-1:0] LEAD_SPACE_MAX = 14'd5000;
    localparam logic [DUR_W-1:0] RPT_SPACE_MIN  = 14'd1900;
    localparam logic [DUR_W-1:0] RPT_SPACE_MAX  = 14'd2600;
    localparam logic [DUR_W-1:0] BIT_MARK_MIN   = 14'd400;
    localparam logic [DUR_W-1:0] BIT_MARK_MAX   = 14'd720;
    localparam logic [DUR_W-1:0] ZERO_SPACE_MIN = 14'd400;
    localparam logic [DUR_W-1:0] ZERO_SPACE_MAX = 14'd720;
    localparam logic [DUR_W-1:0] ONE_SPACE_MIN  = 14'd1400;
    localparam logic [DUR_W-1:0] ONE_SPACE_MAX  = 14'd1900;

    // No edge for this long while a frame is in progress aborts the frame.
    localparam logic [DUR_W-1:0] TIMEOUT_US     = 14'd12000;

    // Receiver FSM state codes.
    localparam int ST_W = 3;
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_STOP_MARK  = 3'd5;
    localparam logic [2:0] S_RPT_MARK   = 3'd6;
    localparam logic [2:0] S_CHECK      = 3'd7;

    // True when d lies within [lo, hi].
    function automatic logic in_win(input logic [DUR_W-1:0] d,
                                    input logic [DUR_W-1:0] lo,
                                    input logic [DUR_W-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // Command byte to {unknown, key[3:0]}; unmapped commands give key 0.
    function automatic logic [4:0] nec_key_map(input logic [7:0] cmd);
        logic [4:0] r;
        case (cmd)
            8'h6D:   r = {1'b0, 4'd0};
            8'hFD:   r = {1'b0, 4'd1};
            8'h7D:   r = {1'b0, 4'd2};
            8'hBD:   r = {1'b0, 4'd3};
            8'h3D:   r = {1'b0, 4'd4};
            8'hDD:   r = {1'b0, 4'd5};
            8'h5D:   r = {1'b0, 4'd6};
            8'h9D:   r = {1'b0, 4'd7};
            8'h1D:   r = {1'b0, 4'd8};
            8'hED:   r = {1'b0, 4'd9};
            default: r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nec_ir_timer.sv
// Timebase for the NEC receiver: a microsecond prescaler feeding a saturating
// edge-to-edge duration counter, plus a millisecond repeat-window timer that
// is reopened by each accepted frame or repeat and closes after REPEAT_WIN_MS.
module nec_ir_timer
    import nec_ir_pkg::*;
#(
    parameter int TICKS_PER_US  = 50,
    parameter int REPEAT_WIN_MS = 110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             edge_i,
    input  logic             win_restart_i,
    output logic [DUR_W-1:0] dur_us_o,
    output logic             win_open_o
);

    localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_US - 1);
    localparam int MS_CYC = TICKS_PER_US * 1000;
    localparam int MSC_W = $clog2(MS_CYC);
    localparam logic [MSC_W-1:0] MSC_LAST = MSC_W'(MS_CYC - 1);
    localparam int MS_W = $clog2(REPEAT_WIN_MS + 1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(REPEAT_WIN_MS - 1);

    logic [PRE_W-1:0] pre_q;
    logic [DUR_W-1:0] dur_q;
    logic [MSC_W-1:0] msc_q;
    logic [MS_W-1:0]  ms_q;
    logic             open_q;
    logic             us_tick;

    assign us_tick    = (pre_q == PRE_LAST);
    assign dur_us_o   = dur_q;
    assign win_open_o = open_q;

    // Prescaler restarts on each edge so durations are measured from the edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (edge_i || us_tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Microseconds since the last edge, saturating so long idle periods stay large.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_q <= '0;
        end else if (edge_i) begin
            dur_q <= '0;
        end else if (us_tick && (dur_q != DUR_MAX)) begin
            dur_q <= dur_q + 1'b1;
        end
    end

    // Repeat window: free-running ms count from the last accepted frame, closing at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= 1'b0;
            msc_q  <= '0;
            ms_q   <= '0;
        end else if (win_restart_i) begin
            open_q <= 1'b1;
            msc_q  <= '0;
            ms_q   <= '0;
        end else if (open_q) begin
            if (msc_q == MSC_LAST) begin
                msc_q <= '0;
                ms_q  <= ms_q + 1'b1;
                if (ms_q == MS_LAST) begin
                    open_q <= 1'b0;
                end
            end else begin
                msc_q <= msc_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR receiver top: synchronises the raw sensor line, detects edges, walks
// the leader/bit/stop sequence by pulse width, assembles the 32-bit frame,
// validates complements and publishes key/addr/cmd plus one-cycle event pulses.
// Event pulses (key_valid, key_repeat, frame_err) come from a single decision
// point per frame, so at most one of them is high in any cycle.
module nec_ir_receiver
    import nec_ir_pkg::*;
#(
    parameter int TICKS_PER_US  = 50,
    parameter int KEY_W         = 4,
    parameter int CHECK_ADDR    = 1,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_WIN_MS = 110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ir_in,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_repeat,
    output logic             key_unknown,
    output logic [15:0]      addr,
    output logic [7:0]       cmd,
    output logic             frame_err,
    output logic [ST_W-1:0]  dbg_state
);

    logic             sync1_q, sync2_q, prev_q;
    logic             fall, rise, any_edge;
    logic [DUR_W-1:0] dur_us;
    logic             win_open;
    logic             win_restart;
    logic             timeout;

    logic [2:0]       state_q, state_d;
    logic [31:0]      sr_q, sr_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic             is_rpt_q, is_rpt_d;

    logic [KEY_W-1:0] key_q, key_d;
    logic             key_unknown_q, key_unknown_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             key_valid_q, key_valid_d;
    logic             key_repeat_q, key_repeat_d;
    logic             frame_err_q, frame_err_d;

    logic             fail;
    logic             cmd_ok, addr_ok;
    logic [4:0]       map;

    // Two-flop synchroniser plus previous-value flop, all idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= ir_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall     = prev_q & ~sync2_q;
    assign rise     = ~prev_q & sync2_q;
    assign any_edge = fall | rise;

    nec_ir_timer #(
        .TICKS_PER_US  (TICKS_PER_US),
        .REPEAT_WIN_MS (REPEAT_WIN_MS)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .edge_i        (any_edge),
        .win_restart_i (win_restart),
        .dur_us_o      (dur_us),
        .win_open_o    (win_open)
    );

    // A frame in progress that sees no edge for TIMEOUT_US is abandoned.
    assign timeout = (state_q != S_IDLE) && (state_q != S_CHECK) && (dur_us >= TIMEOUT_US);

    assign map     = nec_key_map(sr_q[15:8]);
    assign cmd_ok  = ((sr_q[15:8] ^ sr_q[7:0]) == 8'hFF);
    assign addr_ok = (CHECK_ADDR == 0) || ((sr_q[31:24] ^ sr_q[23:16]) == 8'hFF);

    // Next-state logic: width-checks each edge against its window; timeout overrides any edge.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        is_rpt_d      = is_rpt_q;
        key_d         = key_q;
        key_unknown_d = key_unknown_q;
        addr_d        = addr_q;
        cmd_d         = cmd_q;
        key_valid_d   = 1'b0;
        key_repeat_d  = 1'b0;
        frame_err_d   = 1'b0;
        win_restart   = 1'b0;
        fail          = 1'b0;

        if (timeout) begin
            fail = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        state_d   = S_LEAD_MARK;
                        sr_d      = '0;
                        bit_cnt_d = '0;
                        is_rpt_d  = 1'b0;
                    end
                end
                S_LEAD_MARK: begin
                    if (rise) begin
                        if (in_win(dur_us, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                            state_d = S_LEAD_SPACE;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                S_LEAD_SPACE: begin
                    if (fall) begin
                        if (in_win(dur_us, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                            state_d = S_BIT_MARK;
                        end else if ((REPEAT_EN != 0) &&
                                     in_win(dur_us, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                            state_d  = S_RPT_MARK;
                            is_rpt_d = 1'b1;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                S_BIT_MARK: begin
                    if (rise) begin
                        if (in_win(dur_us, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                            state_d = S_BIT_SPACE;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                S_BIT_SPACE: begin
                    if (fall) begin
                        if (in_win(dur_us, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                            in_win(dur_us, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                            sr_d      = {sr_q[30:0], in_win(dur_us, ONE_SPACE_MIN, ONE_SPACE_MAX)};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            state_d   = (bit_cnt_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                S_STOP_MARK, S_RPT_MARK: begin
                    if (rise) begin
                        if (in_win(dur_us, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                            state_d = S_CHECK;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (is_rpt_q) begin
                        if (win_open) begin
                            key_repeat_d = 1'b1;
                            win_restart  = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (cmd_ok && addr_ok) begin
                        key_d         = KEY_W'(map[3:0]);
                        key_unknown_d = map[4];
                        addr_d        = sr_q[31:16];
                        cmd_d         = sr_q[15:8];
                        key_valid_d   = 1'b1;
                        win_restart   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (fail) begin
            state_d     = S_IDLE;
            sr_d        = '0;
            bit_cnt_d   = '0;
            is_rpt_d    = 1'b0;
            frame_err_d = 1'b1;
        end
    end

    // FSM, shift register and published outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            is_rpt_q      <= 1'b0;
            key_q         <= '0;
            key_unknown_q <= 1'b0;
            addr_q        <= '0;
            cmd_q         <= '0;
            key_valid_q   <= 1'b0;
            key_repeat_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            is_rpt_q      <= is_rpt_d;
            key_q         <= key_d;
            key_unknown_q <= key_unknown_d;
            addr_q        <= addr_d;
            cmd_q         <= cmd_d;
            key_valid_q   <= key_valid_d;
            key_repeat_q  <= key_repeat_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign key_repeat  = key_repeat_q;
    assign key_unknown = key_unknown_q;
    assign addr        = addr_q;
    assign cmd         = cmd_q;
    assign frame_err   = frame_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Bench for nec_ir_receiver at TICKS_PER_US=2 (one microsecond = two 10-unit clocks).
module tb_nec_ir_receiver;

  localparam int CLK_P = 10;
  localparam int US_D  = 20;

  logic        clk;
  logic        rst_n;
  logic        ir_in;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_repeat;
  logic        key_unknown;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic        frame_err;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_repeat = 0;
  int n_err = 0;
  int n_excl = 0;
  time last_err_t = 0;

  nec_ir_receiver #(
    .TICKS_PER_US  (2),
    .KEY_W         (4),
    .CHECK_ADDR    (1),
    .REPEAT_EN     (1),
    .REPEAT_WIN_MS (110)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir_in       (ir_in),
    .key         (key),
    .key_valid   (key_valid),
    .key_repeat  (key_repeat),
    .key_unknown (key_unknown),
    .addr        (addr),
    .cmd         (cmd),
    .frame_err   (frame_err),
    .dbg_state   (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #(CLK_P / 2) clk = ~clk;
  end

  // pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (key_valid) n_valid++;
    if (key_repeat) n_repeat++;
    if (frame_err) begin
      n_err++;
      last_err_t = $time;
    end
    if ((int'(key_valid) + int'(key_repeat) + int'(frame_err)) > 1) n_excl++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mark(input int us);
    ir_in = 1'b0;
    #(us * US_D);
  endtask

  task automatic space(input int us);
    ir_in = 1'b1;
    #(us * US_D);
  endtask

  // leader plus the first n bits of w, MSB first; line left high after the last space
  task automatic send_head(input logic [31:0] w, input int n);
    mark(9000);
    space(4500);
    for (int i = 0; i < n; i++) begin
      mark(560);
      space(w[31 - i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_head({b0, b1, b2, b3}, 32);
    mark(560);
    space(300);
  endtask

  task automatic send_repeat();
    mark(9000);
    space(2250);
    mark(560);
    space(300);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  an;
    logic [7:0]  c;
    logic [7:0]  cn;
    logic        ok;
    logic [3:0]  key;
    logic        unk;
    logic [15:0] addr;
    logic [7:0]  cmd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int v0, r0, e0;
    time t0, dt;

    vecs[0] = '{8'h00, 8'hFF, 8'h7D, 8'h82, 1'b1, 4'd2, 1'b0, 16'h00FF, 8'h7D};
    vecs[1] = '{8'h00, 8'hFF, 8'h7D, 8'h83, 1'b0, 4'd2, 1'b0, 16'h00FF, 8'h7D};
    vecs[2] = '{8'h00, 8'hFF, 8'h42, 8'hBD, 1'b1, 4'd0, 1'b1, 16'h00FF, 8'h42};
    vecs[3] = '{8'h12, 8'h34, 8'h6D, 8'h92, 1'b0, 4'd0, 1'b1, 16'h00FF, 8'h42};
    vecs[4] = '{8'h04, 8'hFB, 8'h6D, 8'h92, 1'b1, 4'd0, 1'b0, 16'h04FB, 8'h6D};

    // reset
    rst_n = 1'b0;
    ir_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_key", 32'(key), 0);
    check("rst_outs", {key_valid, key_repeat, key_unknown, frame_err}, 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    space(100);

    // table-driven frames
    for (int i = 0; i < 5; i++) begin
      v0 = n_valid; r0 = n_repeat; e0 = n_err;
      send_frame(vecs[i].a, vecs[i].an, vecs[i].c, vecs[i].cn);
      check($sformatf("v%0d_valid", i), n_valid - v0, vecs[i].ok ? 1 : 0);
      check($sformatf("v%0d_err", i), n_err - e0, vecs[i].ok ? 0 : 1);
      check($sformatf("v%0d_rpt", i), n_repeat - r0, 0);
      check($sformatf("v%0d_key", i), 32'(key), 32'(vecs[i].key));
      check($sformatf("v%0d_unk", i), 32'(key_unknown), 32'(vecs[i].unk));
      check($sformatf("v%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].cmd));
    end

    // repeat inside the window, then one after it has closed
    v0 = n_valid; r0 = n_repeat; e0 = n_err;
    send_frame(8'h00, 8'hFF, 8'h7D, 8'h82);
    check("rf_valid", n_valid - v0, 1);
    check("rf_key", 32'(key), 2);
    space(40000);
    v0 = n_valid; r0 = n_repeat; e0 = n_err;
    send_repeat();
    check("r1_rpt", n_repeat - r0, 1);
    check("r1_err", n_err - e0, 0);
    check("r1_valid", n_valid - v0, 0);
    check("r1_key", 32'(key), 2);
    space(140000);
    v0 = n_valid; r0 = n_repeat; e0 = n_err;
    send_repeat();
    check("r2_rpt", n_repeat - r0, 0);
    check("r2_err", n_err - e0, 1);
    check("r2_key", 32'(key), 2);

    // line stuck low after 17 bits
    e0 = n_err; v0 = n_valid;
    send_head(32'h00FF_ED12, 17);
    ir_in = 1'b0;
    t0 = $time;
    #(13000 * US_D);
    dt = last_err_t - t0;
    check("to_err", n_err - e0, 1);
    check("to_time", 32'((dt >= 12000 * US_D) && (dt <= 12000 * US_D + 20 * CLK_P)), 1);
    check("to_state", 32'(dbg_state), 0);
    check("to_key", 32'(key), 2);
    space(1000);
    send_frame(8'h00, 8'hFF, 8'hED, 8'h12);
    check("to_next_valid", n_valid - v0, 1);
    check("to_next_key", 32'(key), 9);

    // reset in the middle of bit 10
    send_head(32'h00FF_1DE2, 9);
    ir_in = 1'b0;
    #(300 * US_D);
    v0 = n_valid; r0 = n_repeat; e0 = n_err;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ir_in = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_key", 32'(key), 0);
    check("mr_outs", {key_valid, key_repeat, key_unknown, frame_err}, 0);
    check("mr_addr", 32'(addr), 0);
    check("mr_cmd", 32'(cmd), 0);
    check("mr_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    space(15000);
    check("mr_pulses", (n_valid - v0) + (n_repeat - r0) + (n_err - e0), 0);
    v0 = n_valid;
    send_frame(8'h00, 8'hFF, 8'h1D, 8'hE2);
    check("mr_next_valid", n_valid - v0, 1);
    check("mr_next_key", 32'(key), 8);
    check("mr_next_cmd", 32'(cmd), 32'h1D);

    check("exclusive", n_excl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
